// File: rtl/header_buffer_parser_pkg.sv
// Shared state encoding, byte-order helper and header field defaults for the header buffer
// parser and the TCAM/scheduler blocks that consume its key and length.
package header_buffer_parser_pkg;

    localparam int unsigned STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        StIdle   = 3'd0,
        StParse  = 3'd1,
        StLookup = 3'd2,
        StReplay = 3'd3,
        StPass   = 3'd4,
        StDrop   = 3'd5
    } state_e;

    localparam int unsigned DEFAULT_TCAM_KEY_OFFSET      = 0;
    localparam int unsigned DEFAULT_TCAM_KEY_WIDTH       = 48;
    localparam int unsigned DEFAULT_PACKET_LENGTH_OFFSET = 128;
    localparam int unsigned DEFAULT_PACKET_LENGTH_WIDTH  = 16;

    // Widest beat reverse_bytes can handle; narrower beats are zero-extended by the caller.
    localparam int unsigned MAX_DATA_WIDTH = 1024;

    // Lane 0 of the input ends up in the most significant byte of the low num_bytes bytes.
    function automatic logic [MAX_DATA_WIDTH-1:0] reverse_bytes(
        input logic [MAX_DATA_WIDTH-1:0] data,
        input int unsigned               num_bytes
    );
        logic [MAX_DATA_WIDTH-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < MAX_DATA_WIDTH / 8; i++) begin
            if (i < num_bytes) begin
                res[(num_bytes - 1 - i) * 8 +: 8] = data[i * 8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/header_slot_buffer.sv
// Header beat store: DEPTH slots of {tdata, tkeep, tlast} with a raw read port and a
// byte-reversed, keep-masked view of all slots (slot 0 at the MSB end).
module header_slot_buffer
    import header_buffer_parser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_en_i,
    input  logic [IDX_WIDTH-1:0]        wr_idx_i,
    input  logic [DATA_WIDTH-1:0]       wr_data_i,
    input  logic [KEEP_WIDTH-1:0]       wr_keep_i,
    input  logic                        wr_last_i,
    input  logic [IDX_WIDTH-1:0]        rd_idx_i,
    output logic [DATA_WIDTH-1:0]       rd_data_o,
    output logic [KEEP_WIDTH-1:0]       rd_keep_o,
    output logic                        rd_last_o,
    output logic [DEPTH*DATA_WIDTH-1:0] view_o
);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [KEEP_WIDTH-1:0] keep_q [DEPTH];
    logic [DEPTH-1:0]      last_q;

    // Writing slot 0 starts a new packet, so stale slots from the previous one are wiped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                keep_q[i] <= '0;
            end
            last_q <= '0;
        end else if (wr_en_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (IDX_WIDTH'(i) == wr_idx_i) begin
                    data_q[i] <= wr_data_i;
                    keep_q[i] <= wr_keep_i;
                    last_q[i] <= wr_last_i;
                end else if (wr_idx_i == '0) begin
                    data_q[i] <= '0;
                    keep_q[i] <= '0;
                    last_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_keep_o = '0;
        rd_last_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (IDX_WIDTH'(i) == rd_idx_i) begin
                rd_data_o = data_q[i];
                rd_keep_o = keep_q[i];
                rd_last_o = last_q[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_view
        logic [DATA_WIDTH-1:0] masked;

        always_comb begin
            masked = '0;
            for (int unsigned b = 0; b < KEEP_WIDTH; b++) begin
                masked[b * 8 +: 8] = data_q[g][b * 8 +: 8] & {8{keep_q[g][b]}};
            end
        end

        assign view_o[(DEPTH - g) * DATA_WIDTH - 1 -: DATA_WIDTH] =
            DATA_WIDTH'(reverse_bytes(MAX_DATA_WIDTH'(masked), KEEP_WIDTH));
    end

endmodule

// File: rtl/header_buffer_parser.sv
// Store-and-replay header stage: buffers the first HEADER_BEATS beats, presents key/length for
// lookup, then replays or drops. Optional lookup timeout: HEADER_BUFFER_PARSER_TIMEOUT_EN.
module header_buffer_parser
    import header_buffer_parser_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH      = 64,
    parameter int unsigned AXIS_KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
    parameter int unsigned AXIS_DEST_WIDTH      = 2,
    parameter int unsigned HEADER_BEATS         = 3,
    parameter int unsigned TCAM_KEY_OFFSET      = DEFAULT_TCAM_KEY_OFFSET,
    parameter int unsigned TCAM_KEY_WIDTH       = DEFAULT_TCAM_KEY_WIDTH,
    parameter int unsigned PACKET_LENGTH_OFFSET = DEFAULT_PACKET_LENGTH_OFFSET,
    parameter int unsigned PACKET_LENGTH_WIDTH  = DEFAULT_PACKET_LENGTH_WIDTH
`ifdef HEADER_BUFFER_PARSER_TIMEOUT_EN
    ,
    parameter int unsigned LOOKUP_TIMEOUT       = 64
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]     m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [AXIS_DEST_WIDTH-1:0]     m_axis_tdest,
    output logic                           key_valid,
    output logic [TCAM_KEY_WIDTH-1:0]      tcam_key,
    output logic [PACKET_LENGTH_WIDTH-1:0] packet_length,
    input  logic                           decision_valid,
    input  logic                           decision_drop,
    input  logic [AXIS_DEST_WIDTH-1:0]     decision_dest,
    output logic                           short_packet
`ifdef HEADER_BUFFER_PARSER_TIMEOUT_EN
    ,
    output logic                           timeout_drop
`endif
);

    localparam int unsigned VIEW_WIDTH = HEADER_BEATS * AXIS_DATA_WIDTH;
    localparam int unsigned IDX_WIDTH  = (HEADER_BEATS > 1) ? $clog2(HEADER_BEATS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_SLOT = IDX_WIDTH'(HEADER_BEATS - 1);

    if (TCAM_KEY_OFFSET + TCAM_KEY_WIDTH > VIEW_WIDTH ||
        PACKET_LENGTH_OFFSET + PACKET_LENGTH_WIDTH > VIEW_WIDTH ||
        AXIS_DATA_WIDTH > MAX_DATA_WIDTH || HEADER_BEATS < 1) begin : g_param_check
        $error("header_buffer_parser: fields must lie within the buffered header beats");
    end

    state_e                     state_q;
    logic [IDX_WIDTH-1:0]       count_q, rcount_q, last_idx_q;
    logic                       short_q, key_valid_q;
    logic [AXIS_DEST_WIDTH-1:0] dest_q;
    logic                       wr_en;
    logic [AXIS_DATA_WIDTH-1:0] rd_data;
    logic [AXIS_KEEP_WIDTH-1:0] rd_keep;
    logic                       rd_last;
    logic [VIEW_WIDTH-1:0]      view;
    logic                       unused_view_bits;

`ifdef HEADER_BUFFER_PARSER_TIMEOUT_EN
    localparam int unsigned TMO_WIDTH = $clog2(LOOKUP_TIMEOUT + 1);
    logic [TMO_WIDTH-1:0] tmo_cnt_q;
    logic                 timeout_drop_q;
    assign timeout_drop = timeout_drop_q;
`endif

    assign wr_en = (state_q == StIdle || state_q == StParse) && s_axis_tvalid;

    header_slot_buffer #(
        .DATA_WIDTH (AXIS_DATA_WIDTH),
        .KEEP_WIDTH (AXIS_KEEP_WIDTH),
        .DEPTH      (HEADER_BEATS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_slots (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_idx_i  (count_q),
        .wr_data_i (s_axis_tdata),
        .wr_keep_i (s_axis_tkeep),
        .wr_last_i (s_axis_tlast),
        .rd_idx_i  (rcount_q),
        .rd_data_o (rd_data),
        .rd_keep_o (rd_keep),
        .rd_last_o (rd_last),
        .view_o    (view)
    );

    assign tcam_key         = view[VIEW_WIDTH - 1 - TCAM_KEY_OFFSET -: TCAM_KEY_WIDTH];
    assign packet_length    = view[VIEW_WIDTH - 1 - PACKET_LENGTH_OFFSET -: PACKET_LENGTH_WIDTH];
    assign unused_view_bits = ^view;
    assign key_valid        = key_valid_q;
    assign short_packet     = short_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            rcount_q    <= '0;
            last_idx_q  <= '0;
            short_q     <= 1'b0;
            key_valid_q <= 1'b0;
            dest_q      <= '0;
`ifdef HEADER_BUFFER_PARSER_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            timeout_drop_q <= 1'b0;
`endif
        end else begin
`ifdef HEADER_BUFFER_PARSER_TIMEOUT_EN
            timeout_drop_q <= 1'b0;
`endif
            case (state_q)
                StIdle, StParse: begin
                    if (s_axis_tvalid) begin
                        if (s_axis_tlast || count_q == LAST_SLOT) begin
                            state_q     <= StLookup;
                            key_valid_q <= 1'b1;
                            short_q     <= s_axis_tlast;
                            last_idx_q  <= count_q;
                            count_q     <= '0;
`ifdef HEADER_BUFFER_PARSER_TIMEOUT_EN
                            tmo_cnt_q   <= '0;
`endif
                        end else begin
                            state_q <= StParse;
                            count_q <= count_q + IDX_WIDTH'(1);
                        end
                    end
                end
                StLookup: begin
                    // A short packet has already been fully consumed, so a drop needs no DROP state.
                    if (decision_valid) begin
                        key_valid_q <= 1'b0;
                        dest_q      <= decision_dest;
                        rcount_q    <= '0;
                        if (decision_drop) begin
                            state_q <= short_q ? StIdle : StDrop;
                        end else begin
                            state_q <= StReplay;
                        end
                    end
`ifdef HEADER_BUFFER_PARSER_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_WIDTH'(LOOKUP_TIMEOUT - 1)) begin
                        key_valid_q    <= 1'b0;
                        timeout_drop_q <= 1'b1;
                        state_q        <= short_q ? StIdle : StDrop;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_WIDTH'(1);
                    end
`endif
                end
                StReplay: begin
                    if (m_axis_tready) begin
                        if (rcount_q == last_idx_q) begin
                            rcount_q <= '0;
                            state_q  <= short_q ? StIdle : StPass;
                        end else begin
                            rcount_q <= rcount_q + IDX_WIDTH'(1);
                        end
                    end
                end
                StPass: begin
                    if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                        state_q <= StIdle;
                    end
                end
                StDrop: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tdest  = '0;
        case (state_q)
            StIdle, StParse, StDrop: s_axis_tready = 1'b1;
            StReplay: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = rd_data;
                m_axis_tkeep  = rd_keep;
                m_axis_tlast  = rd_last;
                m_axis_tdest  = dest_q;
            end
            StPass: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tdest  = dest_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_header_buffer_parser.sv
// Bench for header_buffer_parser: packet table drives the input, a decider answers lookups,
// and a scoreboard checks every output beat.
module tb_header_buffer_parser;

    logic        clk, rst;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [1:0]  m_axis_tdest;
    logic        key_valid;
    logic [47:0] tcam_key;
    logic [15:0] packet_length;
    logic        decision_valid, decision_drop;
    logic [1:0]  decision_dest;
    logic        short_packet;
`ifdef HEADER_BUFFER_PARSER_TIMEOUT_EN
    logic        timeout_drop;
`endif

    header_buffer_parser dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tdest   (m_axis_tdest),
        .key_valid      (key_valid),
        .tcam_key       (tcam_key),
        .packet_length  (packet_length),
        .decision_valid (decision_valid),
        .decision_drop  (decision_drop),
        .decision_dest  (decision_dest),
        .short_packet   (short_packet)
`ifdef HEADER_BUFFER_PARSER_TIMEOUT_EN
        ,
        .timeout_drop   (timeout_drop)
`endif
    );

    typedef struct {
        int          pat;
        int          nbeats;
        logic [7:0]  last_keep;
        logic [1:0]  dest;
        logic        drop;
        int          delay;
        logic        bp;
        logic [47:0] exp_key;
        logic [15:0] exp_len;
        logic        exp_short;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [1:0]  dest;
    } beat_t;

    localparam int NVEC = 9;
    vec_t  vecs [NVEC];
    beat_t exp_q [$];
    int    total = 0;
    int    bad = 0;
    int    n_out = 0;
    logic  bp_mode = 1'b0;
    logic  stall_q = 1'b0;
    logic [63:0] held_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    function automatic logic [7:0] pbyte(input int pat, input int k);
        if (pat == 0) begin
            if (k < 6) return 8'(8'h0A + k);
            if (k == 16) return 8'h00;
            if (k == 17) return 8'h54;
        end
        return 8'(pat * 16 + k);
    endfunction

    function automatic beat_t make_beat(input int pat, input int b, input int nbeats,
                                        input logic [7:0] last_keep, input logic [1:0] dest);
        beat_t e;
        for (int j = 0; j < 8; j++) e.data[j * 8 +: 8] = pbyte(pat, b * 8 + j);
        e.last = (b == nbeats - 1);
        e.keep = e.last ? last_keep : 8'hFF;
        e.dest = dest;
        return e;
    endfunction

    task automatic drive_beat(input beat_t e, output bit ok);
        int w = 0;
        s_axis_tdata  = e.data;
        s_axis_tkeep  = e.keep;
        s_axis_tlast  = e.last;
        s_axis_tvalid = 1'b1;
        ok = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            w++;
            if (w > 400) begin
                ok = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic run_driver();
        bit ok;
        for (int p = 0; p < NVEC; p++) begin
            for (int b = 0; b < vecs[p].nbeats; b++) begin
                if (!vecs[p].drop)
                    exp_q.push_back(make_beat(vecs[p].pat, b, vecs[p].nbeats,
                                              vecs[p].last_keep, vecs[p].dest));
            end
            for (int b = 0; b < vecs[p].nbeats; b++) begin
                drive_beat(make_beat(vecs[p].pat, b, vecs[p].nbeats, vecs[p].last_keep,
                                     vecs[p].dest), ok);
                if (!ok) begin
                    fail_now($sformatf("s_ready_timeout_pkt%0d", p));
                    return;
                end
            end
        end
    endtask

    task automatic run_decider();
        for (int p = 0; p < NVEC; p++) begin
            int w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!key_valid && w < 400);
            if (!key_valid) begin
                fail_now($sformatf("key_valid_timeout_pkt%0d", p));
                return;
            end
            check($sformatf("key_pkt%0d", p), 64'(tcam_key), 64'(vecs[p].exp_key));
            check($sformatf("len_pkt%0d", p), 64'(packet_length), 64'(vecs[p].exp_len));
            check($sformatf("short_pkt%0d", p), 64'(short_packet), 64'(vecs[p].exp_short));
            bp_mode = vecs[p].bp;
            @(posedge clk);
            #1;
            repeat (vecs[p].delay) begin
                @(posedge clk);
                #1;
            end
            decision_valid = 1'b1;
            decision_drop  = vecs[p].drop;
            decision_dest  = vecs[p].dest;
            @(posedge clk);
            #1;
            decision_valid = 1'b0;
            @(negedge clk);
            check($sformatf("key_clear_pkt%0d", p), 64'(key_valid), 64'd0);
        end
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = bp_mode ? !m_axis_tready : 1'b1;
        end
    end

    // Scoreboard: compare each accepted output beat, and hold-stability across stalls.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_q) check("stall_hold_tdata", m_axis_tdata, held_data);
            stall_q   = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output_beat");
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check($sformatf("tdata_beat%0d", n_out), m_axis_tdata, e.data);
                    check($sformatf("tkeep_beat%0d", n_out), 64'(m_axis_tkeep), 64'(e.keep));
                    check($sformatf("tlast_beat%0d", n_out), 64'(m_axis_tlast), 64'(e.last));
                    check($sformatf("tdest_beat%0d", n_out), 64'(m_axis_tdest), 64'(e.dest));
                end
                n_out++;
            end
        end else begin
            stall_q = 1'b0;
        end
    end

    initial begin
        int exp_beats = 0;
        int w = 0;
        bit ok;
        //          pat nb  lkeep  dst drop dly bp  key               len      short
        vecs[0] = '{0,  4, 8'hFF, 2'd2, 0, 0, 0, 48'h0A0B0C0D0E0F, 16'h0054, 1'b0};
        vecs[1] = '{0,  4, 8'hFF, 2'd1, 1, 0, 0, 48'h0A0B0C0D0E0F, 16'h0054, 1'b0};
        vecs[2] = '{2,  1, 8'h0F, 2'd1, 0, 0, 0, 48'h202122230000, 16'h0000, 1'b1};
        vecs[3] = '{3,  5, 8'hFF, 2'd3, 0, 1, 1, 48'h303132333435, 16'h4041, 1'b0};
        vecs[4] = '{4,  5, 8'hFF, 2'd1, 0, 3, 0, 48'h404142434445, 16'h5051, 1'b0};
        vecs[5] = '{5,  5, 8'hFF, 2'd2, 0, 3, 0, 48'h505152535455, 16'h6061, 1'b0};
        vecs[6] = '{6,  2, 8'h03, 2'd0, 0, 0, 0, 48'h606162636465, 16'h0000, 1'b1};
        vecs[7] = '{7,  1, 8'hFF, 2'd3, 1, 0, 0, 48'h707172737475, 16'h0000, 1'b1};
        vecs[8] = '{8,  4, 8'hFF, 2'd1, 0, 0, 0, 48'h808182838485, 16'h9091, 1'b0};
        for (int p = 0; p < NVEC; p++) if (!vecs[p].drop) exp_beats += vecs[p].nbeats;

        rst = 1'b1;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        decision_valid = 1'b0;
        decision_drop = 1'b0;
        decision_dest = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_s_tready", 64'(s_axis_tready), 64'd1);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_key_valid", 64'(key_valid), 64'd0);
        check("rst_tcam_key", 64'(tcam_key), 64'd0);
        check("rst_length", 64'(packet_length), 64'd0);
        check("rst_short", 64'(short_packet), 64'd0);

        // A decision outside LOOKUP must be ignored.
        @(posedge clk);
        #1;
        decision_valid = 1'b1;
        decision_drop  = 1'b1;
        decision_dest  = 2'd3;
        @(posedge clk);
        #1;
        decision_valid = 1'b0;
        @(negedge clk);
        check("stray_dec_key_valid", 64'(key_valid), 64'd0);
        check("stray_dec_s_tready", 64'(s_axis_tready), 64'd1);
        @(posedge clk);
        #1;

        fork
            run_driver();
            run_decider();
        join

        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("output_beat_count", 64'(n_out), 64'(exp_beats));
        bp_mode = 1'b0;
        @(negedge clk);
        check("end_idle_s_tready", 64'(s_axis_tready), 64'd1);
        check("end_m_tvalid", 64'(m_axis_tvalid), 64'd0);

        // Reset while a key is pending clears the key and returns to IDLE.
        @(posedge clk);
        #1;
        for (int b = 0; b < 3; b++) begin
            drive_beat(make_beat(9, b, 6, 8'hFF, 2'd0), ok);
            if (!ok) fail_now("midrst_s_ready_timeout");
        end
        @(negedge clk);
        check("midrst_key_valid_pre", 64'(key_valid), 64'd1);
        check("midrst_key_pre", 64'(tcam_key), 64'h909192939495);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_key_valid", 64'(key_valid), 64'd0);
        check("midrst_tcam_key", 64'(tcam_key), 64'd0);
        check("midrst_length", 64'(packet_length), 64'd0);
        check("midrst_s_tready", 64'(s_axis_tready), 64'd1);
        check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
